// File: rtl/one_bit_comparator_if.sv
// Operand, control and result bundle for the registered one-bit comparator.
interface one_bit_comparator_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             b;
  logic             in_valid;
  logic             clr_cnt;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             out_valid;
  logic             changed;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;

  modport master (
    output a, b, in_valid, clr_cnt,
    input  lt, gt, eq, out_valid, changed, lt_cnt, gt_cnt, eq_cnt
  );

  modport slave (
    input  a, b, in_valid, clr_cnt,
    output lt, gt, eq, out_valid, changed, lt_cnt, gt_cnt, eq_cnt
  );
endinterface

// File: rtl/one_bit_comparator.sv
// Registered 1-bit magnitude comparator with one-hot lt/gt/eq flags,
// saturating per-outcome counters and a result-changed flag.
module one_bit_comparator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  one_bit_comparator_if.slave bus
);

  logic             lt_q, gt_q, eq_q;
  logic             out_valid_q;
  logic             changed_q;
  logic             hist_q;
  logic [CNT_W-1:0] lt_cnt_q, gt_cnt_q, eq_cnt_q;

  logic             lt_n, gt_n, eq_n;

  // Operands are only consulted under in_valid, so X while idle cannot leak into state.
  always_comb begin
    lt_n = ~bus.a &  bus.b;
    gt_n =  bus.a & ~bus.b;
    eq_n = ~(bus.a ^ bus.b);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      changed_q   <= 1'b0;
      hist_q      <= 1'b0;
      lt_cnt_q    <= '0;
      gt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        lt_q <= lt_n;
        gt_q <= gt_n;
        eq_q <= eq_n;
      end
      // A same-cycle sample still updates the flags above but is neither
      // counted nor remembered as history when the clear wins.
      if (bus.clr_cnt) begin
        changed_q <= 1'b0;
        hist_q    <= 1'b0;
        lt_cnt_q  <= '0;
        gt_cnt_q  <= '0;
        eq_cnt_q  <= '0;
      end else if (bus.in_valid) begin
        changed_q <= hist_q && ({lt_n, gt_n, eq_n} != {lt_q, gt_q, eq_q});
        hist_q    <= 1'b1;
        if (lt_n) lt_cnt_q <= sat_inc(lt_cnt_q);
        if (gt_n) gt_cnt_q <= sat_inc(gt_cnt_q);
        if (eq_n) eq_cnt_q <= sat_inc(eq_cnt_q);
      end
    end
  end

  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.out_valid = out_valid_q;
  assign bus.changed   = changed_q;
  assign bus.lt_cnt    = lt_cnt_q;
  assign bus.gt_cnt    = gt_cnt_q;
  assign bus.eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_one_bit_comparator.sv
// Directed-vector bench for one_bit_comparator, built with 2-bit counters
// so saturation is reachable in a few samples.
module tb_one_bit_comparator;

  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  one_bit_comparator_if #(.CNT_W(CNT_W)) bus ();

  one_bit_comparator #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic step(input logic r, input logic v, input logic clr,
                      input logic a, input logic b);
    rst          = r;
    bus.in_valid = v;
    bus.clr_cnt  = clr;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  // Expected {lt,gt,eq}, out_valid, changed, lt_cnt, gt_cnt, eq_cnt.
  task automatic expect_all(input string tag, input logic [2:0] flags,
                            input logic ov, input logic ch,
                            input logic [CNT_W-1:0] lc, input logic [CNT_W-1:0] gc,
                            input logic [CNT_W-1:0] ec);
    check({tag, ".flags"},   32'({bus.lt, bus.gt, bus.eq}), 32'(flags));
    check({tag, ".ovalid"},  32'(bus.out_valid), 32'(ov));
    check({tag, ".changed"}, 32'(bus.changed), 32'(ch));
    check({tag, ".lt_cnt"},  32'(bus.lt_cnt), 32'(lc));
    check({tag, ".gt_cnt"},  32'(bus.gt_cnt), 32'(gc));
    check({tag, ".eq_cnt"},  32'(bus.eq_cnt), 32'(ec));
  endtask

  initial begin
    logic [CNT_W-1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held with a live (1,0) sample: nothing may register.
    step(1, 1, 0, 1, 0);
    expect_all("rst0", 3'b000, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    expect_all("rst1", 3'b000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_all("rst_rel", 3'b000, 0, 0, 0, 0, 0);

    // Truth table on consecutive cycles.
    step(0, 1, 0, 0, 0);
    expect_all("tt00", 3'b001, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    expect_all("tt01", 3'b100, 1, 1, 1, 0, 1);
    step(0, 1, 0, 1, 0);
    expect_all("tt10", 3'b010, 1, 1, 1, 1, 1);
    step(0, 1, 0, 1, 1);
    expect_all("tt11", 3'b001, 1, 1, 1, 1, 2);

    // Hold: idle cycles with toggling and unknown operands.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    expect_all("hold_s", 3'b100, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_all("hold1", 3'b100, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1'bx, 1'bx);
    expect_all("hold2", 3'b100, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1'bx);
    expect_all("hold3", 3'b100, 0, 0, 1, 0, 0);

    // Saturation of the 2-bit gt counter.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 0);
      expect_all($sformatf("sat%0d", i), 3'b010, 1, 0, 0, sat_exp[i], 0);
    end

    // Clear with a same-cycle (1,1) sample, then first post-clear sample.
    step(0, 1, 1, 1, 1);
    expect_all("clr", 3'b001, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    expect_all("clr_next", 3'b100, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    expect_all("clr_next2", 3'b100, 1, 0, 2, 0, 0);

    // Mid-stream reset between two (1,0) samples discards the in-flight one.
    step(0, 1, 0, 1, 0);
    expect_all("mr_pre", 3'b010, 1, 1, 2, 1, 0);
    step(1, 1, 0, 1, 0);
    expect_all("mr_rst", 3'b000, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    expect_all("mr_post", 3'b010, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    expect_all("mr_idle", 3'b010, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
